// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the in-order backend: tracks load-use,
// multi-cycle muldiv occupancy and the data-memory handshake, and drives stall/kill per stage.
module pipe_ctrl #(
  parameter int LREG_W     = 5,
  parameter int MULDIV_LAT = 4,
  parameter int PERF_W     = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [LREG_W-1:0] id_rs1,
  input  logic [LREG_W-1:0] id_rs2,
  input  logic              id_src1_is_reg,
  input  logic              id_src2_is_reg,
  input  logic              ex_valid,
  input  logic [LREG_W-1:0] ex_rd,
  input  logic              ex_need_to_wb,
  input  logic              ex_is_load,
  input  logic              ex_is_muldiv,
  input  logic              redirect_valid,
  input  logic              mem_valid,
  input  logic              mem_is_ls,
  input  logic              dmem_req_ready,
  input  logic              dmem_resp_valid,
  output logic              dmem_req_valid,
  output logic              if_id_stall,
  output logic              id_ex_stall,
  output logic              ex_mem_stall,
  output logic              mem_wb_stall,
  output logic              if_id_kill,
  output logic              id_ex_kill,
  output logic              ex_mem_kill,
  output logic              mem_wb_kill,
  output logic              flush_fire,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT} mem_state_e;

  localparam int                MD_W    = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [MD_W-1:0]   MD_LAST = MD_W'(MULDIV_LAT - 1);

  mem_state_e        mem_state_q, mem_state_d;
  logic [MD_W-1:0]   md_cnt_q, md_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_pending, mem_stall, md_stall, ex_hold, flush, load_use;
  logic rs1_hit, rs2_hit;

  assign mem_pending = mem_valid & mem_is_ls;
  // A response only retires the op once the request has actually been accepted.
  assign mem_stall   = mem_pending & ~((mem_state_q == M_WAIT) & dmem_resp_valid);
  assign md_stall    = ex_valid & ex_is_muldiv & (md_cnt_q != MD_LAST);
  assign ex_hold     = mem_stall | md_stall;
  assign flush       = redirect_valid & ex_valid & ~ex_hold;

  assign rs1_hit  = id_src1_is_reg & (id_rs1 == ex_rd);
  assign rs2_hit  = id_src2_is_reg & (id_rs2 == ex_rd);
  assign load_use = ex_valid & ex_is_load & ex_need_to_wb & (ex_rd != '0) & id_valid
                  & (rs1_hit | rs2_hit);

  assign dmem_req_valid = ((mem_state_q == M_IDLE) & mem_pending) | (mem_state_q == M_REQ);

  assign mem_wb_stall = 1'b0;
  assign mem_wb_kill  = mem_stall;
  assign ex_mem_stall = mem_stall;
  assign ex_mem_kill  = md_stall & ~mem_stall;
  assign id_ex_stall  = ex_hold;
  assign id_ex_kill   = ~ex_hold & (flush | load_use);
  assign if_id_stall  = ex_hold | (load_use & ~flush);
  assign if_id_kill   = flush;
  assign flush_fire   = flush;
  assign stall_cycles = stall_cnt_q;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    mem_state_d = mem_state_q;
    unique case (mem_state_q)
      M_IDLE:  if (mem_pending) mem_state_d = dmem_req_ready ? M_WAIT : M_REQ;
      M_REQ:   if (dmem_req_ready) mem_state_d = M_WAIT;
      M_WAIT:  if (dmem_resp_valid) mem_state_d = M_IDLE;
      default: mem_state_d = M_IDLE;
    endcase
  end

  // Count saturates at MD_LAST while EX is held only by a memory stall.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (!ex_hold)      md_cnt_d = '0;
    else if (md_stall) md_cnt_d = md_cnt_q + MD_W'(1);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (if_id_stall) stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_state_q <= M_IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      mem_state_q <= mem_state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus randomized
// stimulus compared every cycle against a behavioural model of the controller.
module tb_pipe_ctrl;
  localparam int LREG_W     = 5;
  localparam int MULDIV_LAT = 4;
  localparam int PERF_W     = 32;

  logic clock = 1'b0;
  logic reset_n;
  logic id_valid, id_src1_is_reg, id_src2_is_reg;
  logic [LREG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic ex_valid, ex_need_to_wb, ex_is_load, ex_is_muldiv, redirect_valid;
  logic mem_valid, mem_is_ls, dmem_req_ready, dmem_resp_valid;
  logic dmem_req_valid, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic if_id_kill, id_ex_kill, ex_mem_kill, mem_wb_kill, flush_fire;
  logic [PERF_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_err    = 0;

  pipe_ctrl #(.LREG_W(LREG_W), .MULDIV_LAT(MULDIV_LAT), .PERF_W(PERF_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_src1_is_reg(id_src1_is_reg), .id_src2_is_reg(id_src2_is_reg),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_need_to_wb(ex_need_to_wb),
    .ex_is_load(ex_is_load), .ex_is_muldiv(ex_is_muldiv),
    .redirect_valid(redirect_valid), .mem_valid(mem_valid), .mem_is_ls(mem_is_ls),
    .dmem_req_ready(dmem_req_ready), .dmem_resp_valid(dmem_resp_valid),
    .dmem_req_valid(dmem_req_valid), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall), .if_id_kill(if_id_kill),
    .id_ex_kill(id_ex_kill), .ex_mem_kill(ex_mem_kill), .mem_wb_kill(mem_wb_kill),
    .flush_fire(flush_fire), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a memory op is either waiting to be accepted or waiting
  // for its response; a muldiv tracks how many cycles it has already spent in EX.
  logic        m_req_out = 1'b0;
  logic        m_await   = 1'b0;
  int          m_md_age  = 0;
  logic [31:0] m_stalls  = '0;

  always @(negedge clock) begin
    logic pend, rq, rok, ms, mds, hold, lu, fl, ifs;
    logic [10:0] exp_v, act_v;
    if (!reset_n) begin
      m_req_out = 1'b0; m_await = 1'b0; m_md_age = 0; m_stalls = '0;
    end
    pend = mem_valid && mem_is_ls && !m_req_out && !m_await;
    rq   = pend || m_req_out;
    rok  = m_await && dmem_resp_valid;
    ms   = mem_valid && mem_is_ls && !rok;
    mds  = ex_valid && ex_is_muldiv && (m_md_age < MULDIV_LAT - 1);
    hold = ms || mds;
    fl   = redirect_valid && ex_valid && !hold;
    lu   = ex_valid && ex_is_load && ex_need_to_wb && (ex_rd != 0) && id_valid &&
           ((id_src1_is_reg && id_rs1 == ex_rd) || (id_src2_is_reg && id_rs2 == ex_rd));
    ifs  = hold || (lu && !fl);
    exp_v = {rq, ifs, hold, ms, 1'b0, fl, !hold && (fl || lu), mds && !ms, ms, fl, 1'b0};
    act_v = {dmem_req_valid, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
             if_id_kill, id_ex_kill, ex_mem_kill, mem_wb_kill, flush_fire, 1'b0};
    check("model_outputs", 64'(act_v), 64'(exp_v));
    check("model_stall_cycles", 64'(stall_cycles), 64'(m_stalls));
    if (reset_n) begin
      m_await   = (rq && dmem_req_ready) || (m_await && !dmem_resp_valid);
      m_req_out = rq && !dmem_req_ready;
      if (!hold)    m_md_age = 0;
      else if (mds) m_md_age = m_md_age + 1;
      if (ifs)      m_stalls = m_stalls + 32'd1;
    end
  end

  task automatic clear_inputs();
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_src1_is_reg = 0; id_src2_is_reg = 0;
    ex_valid = 0; ex_rd = '0; ex_need_to_wb = 0; ex_is_load = 0; ex_is_muldiv = 0;
    redirect_valid = 0; mem_valid = 0; mem_is_ls = 0; dmem_req_ready = 0; dmem_resp_valid = 0;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic setup_load_use(input logic [LREG_W-1:0] rd, input logic src1);
    ex_valid = 1; ex_is_load = 1; ex_need_to_wb = 1; ex_rd = rd;
    id_valid = 1; id_rs1 = 5'd5; id_src1_is_reg = src1;
  endtask

  task automatic rand_inputs();
    if ($urandom_range(0, 2) == 0) id_valid       = 1'($urandom);
    if ($urandom_range(0, 2) == 0) id_rs1         = LREG_W'($urandom_range(0, 3));
    if ($urandom_range(0, 2) == 0) id_rs2         = LREG_W'($urandom_range(0, 3));
    if ($urandom_range(0, 2) == 0) id_src1_is_reg = 1'($urandom);
    if ($urandom_range(0, 2) == 0) id_src2_is_reg = 1'($urandom);
    if ($urandom_range(0, 4) == 0) ex_valid       = 1'($urandom);
    if ($urandom_range(0, 2) == 0) ex_rd          = LREG_W'($urandom_range(0, 3));
    if ($urandom_range(0, 2) == 0) ex_need_to_wb  = 1'($urandom);
    if ($urandom_range(0, 3) == 0) ex_is_load     = 1'($urandom);
    if ($urandom_range(0, 5) == 0) ex_is_muldiv   = 1'($urandom);
    redirect_valid  = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 4) == 0) mem_valid      = 1'($urandom);
    if ($urandom_range(0, 4) == 0) mem_is_ls      = 1'($urandom);
    dmem_req_ready  = 1'($urandom);
    dmem_resp_valid = 1'($urandom);
  endtask

  initial begin
    int req_cnt, stl_cnt;
    logic [PERF_W-1:0] start_cnt;
    clear_inputs();
    reset_n = 1;
    #1 reset_n = 0;
    @(negedge clock);
    check("reset_stall_cycles", 64'(stall_cycles), 64'd0);
    check("reset_if_id_stall", 64'(if_id_stall), 64'd0);
    check("reset_dmem_req_valid", 64'(dmem_req_valid), 64'd0);
    step(); reset_n = 1;

    // Load-use on rs1: one bubble, then clear once EX holds a bubble.
    setup_load_use(5'd5, 1'b1);
    @(negedge clock);
    check("lu_if_id_stall", 64'(if_id_stall), 64'd1);
    check("lu_id_ex_kill", 64'(id_ex_kill), 64'd1);
    step(); ex_valid = 0;
    @(negedge clock);
    check("lu_next_if_id_stall", 64'(if_id_stall), 64'd0);
    check("lu_next_id_ex_kill", 64'(id_ex_kill), 64'd0);
    step(); setup_load_use(5'd0, 1'b1); id_rs1 = 5'd0;
    @(negedge clock);
    check("lu_x0_if_id_stall", 64'(if_id_stall), 64'd0);
    step(); setup_load_use(5'd5, 1'b0);
    @(negedge clock);
    check("lu_nosrc_if_id_stall", 64'(if_id_stall), 64'd0);
    step(); clear_inputs();

    // Muldiv occupies EX for MULDIV_LAT cycles.
    ex_valid = 1; ex_is_muldiv = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("md_id_ex_stall", 64'(id_ex_stall), 64'(k < 3));
      check("md_ex_mem_kill", 64'(ex_mem_kill), 64'(k < 3));
      step();
    end
    @(negedge clock);
    check("md_restart_id_ex_stall", 64'(id_ex_stall), 64'd1);
    step(); clear_inputs();
    repeat (4) step();

    // Load in MEM: ready low 2 cycles, accepted on the 3rd, response 3 cycles after.
    req_cnt = 0; stl_cnt = 0; start_cnt = '0;
    mem_valid = 1; mem_is_ls = 1;
    for (int c = 0; c < 7; c++) begin
      dmem_req_ready  = (c == 2);
      dmem_resp_valid = (c == 6);
      @(negedge clock);
      if (c == 0) start_cnt = stall_cycles;
      if (dmem_req_valid) req_cnt++;
      if (ex_mem_stall) stl_cnt++;
      if (c == 6) check("mem_resp_ex_mem_stall", 64'(ex_mem_stall), 64'd0);
      step();
    end
    clear_inputs();
    @(negedge clock);
    check("mem_req_valid_cycles", 64'(req_cnt), 64'd3);
    check("mem_stall_cycles", 64'(stl_cnt), 64'd6);
    check("mem_perf_delta", 64'(stall_cycles - start_cnt), 64'd6);
    step();

    // Redirect deferred behind a memory stall, then wins over load-use.
    mem_valid = 1; mem_is_ls = 1; dmem_req_ready = 1;
    setup_load_use(5'd5, 1'b1); redirect_valid = 1;
    @(negedge clock);
    check("rd_deferred_flush", 64'(flush_fire), 64'd0);
    step(); dmem_req_ready = 0; dmem_resp_valid = 1;
    @(negedge clock);
    check("rd_flush_fire", 64'(flush_fire), 64'd1);
    check("rd_if_id_kill", 64'(if_id_kill), 64'd1);
    check("rd_id_ex_kill", 64'(id_ex_kill), 64'd1);
    check("rd_if_id_stall", 64'(if_id_stall), 64'd0);
    step(); clear_inputs();

    // Reset while waiting for a response; the stale response must be ignored.
    mem_valid = 1; mem_is_ls = 1; dmem_req_ready = 1;
    step(); clear_inputs(); reset_n = 0;
    @(negedge clock);
    check("rst_ex_mem_stall", 64'(ex_mem_stall), 64'd0);
    step(); reset_n = 1; dmem_resp_valid = 1;
    @(negedge clock);
    check("rst_stale_outputs", 64'({if_id_stall, id_ex_stall, ex_mem_stall, if_id_kill,
                                    id_ex_kill, ex_mem_kill, mem_wb_kill}), 64'd0);
    check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    step(); mem_valid = 1; mem_is_ls = 1; dmem_req_ready = 1; dmem_resp_valid = 1;
    @(negedge clock);
    check("rst_idle_ignores_resp", 64'(ex_mem_stall), 64'd1);
    step(); dmem_req_ready = 0; dmem_resp_valid = 1;
    @(negedge clock);
    check("rst_resp_retires", 64'(ex_mem_stall), 64'd0);
    step(); clear_inputs();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      reset_n = ($urandom_range(0, 199) != 0);
      step();
    end
    reset_n = 1; clear_inputs();
    @(negedge clock);
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush controller for the in-order backend; it drives the `stall` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and gates their `valid` inputs to insert bubbles.
- Consumes the registered outputs of those pipeline registers, tracks load-use hazards, multi-cycle muldiv occupancy, and the data-memory request/response handshake.
- Issues branch-redirect flushes.

Parameters:
- LREG_W, 5, logical register index width
- MULDIV_LAT, 4, total cycles a muldiv op occupies EX (>=1)
- PERF_W, 32, width of stall-cycle performance counter

Ports:
- clock  in  1  clock
- reset_n  in  1  async active-low reset
- id_valid  in  1  decode-stage instruction valid
- id_rs1  in  LREG_W  decode rs1
- id_rs2  in  LREG_W  decode rs2
- id_src1_is_reg  in  1  rs1 actually read
- id_src2_is_reg  in  1  rs2 actually read
- ex_valid  in  1  ID/EX register out_valid
- ex_rd  in  LREG_W  ID/EX out_rd
- ex_need_to_wb  in  1  ID/EX out_need_to_wb
- ex_is_load  in  1  ID/EX out_is_load
- ex_is_muldiv  in  1  ID/EX out_muldiv_type != 0
- redirect_valid  in  1  BJU mispredict in EX
- mem_valid  in  1  EX/MEM out_valid
- mem_is_ls  in  1  EX/MEM out_is_load | out_is_store
- dmem_req_ready  in  1  dmem accepts request
- dmem_resp_valid  in  1  dmem response
- dmem_req_valid  out  1  dmem request
- if_id_stall  out  1  hold IF/ID
- id_ex_stall  out  1  hold ID/EX
- ex_mem_stall  out  1  hold EX/MEM
- mem_wb_stall  out  1  hold MEM/WB (tied 0)
- if_id_kill  out  1  force IF/ID valid input to 0
- id_ex_kill  out  1  force ID/EX valid input to 0
- ex_mem_kill  out  1  force EX/MEM valid input to 0
- mem_wb_kill  out  1  force MEM/WB valid input to 0
- flush_fire  out  1  redirect accepted, fetch must redirect
- stall_cycles  out  PERF_W  count of cycles with if_id_stall=1

Behaviour:
- Reset (async, reset_n low): mem FSM = M_IDLE, md_cnt = 0, stall_cycles = 0. Combinational outputs evaluate with ex/mem valids as driven, so all are 0 when the pipeline registers are reset.
- Mem FSM states are M_IDLE, M_REQ, M_WAIT:
  - M_IDLE: a request is pending when mem_valid & mem_is_ls. If pending & dmem_req_ready, go to M_WAIT; if pending & ~ready, go to M_REQ.
  - M_REQ: go to M_WAIT on dmem_req_ready.
  - M_WAIT: go to M_IDLE on dmem_resp_valid.
  - dmem_resp_valid is ignored outside M_WAIT.
  - dmem_req_valid = (M_IDLE & pending) | M_REQ.
- mem_stall = mem_valid & mem_is_ls & ~(M_WAIT & dmem_resp_valid). Minimum memory-op occupancy of MEM is 2 cycles (request accepted in cycle 0, response in cycle 1).
- Muldiv:
  - md_stall = ex_valid & ex_is_muldiv & (md_cnt != MULDIV_LAT-1).
  - md_cnt increments while md_stall; it saturates at MULDIV_LAT-1 while EX is held by mem_stall.
  - md_cnt clears to 0 when id_ex_stall=0. MULDIV_LAT=1 means md_stall is never asserted.
- Load-use: load_use = ex_valid & ex_is_load & ex_need_to_wb & (ex_rd != 0) & id_valid & ((id_src1_is_reg & id_rs1==ex_rd) | (id_src2_is_reg & id_rs2==ex_rd)).
- Hold chain:
  - ex_hold = mem_stall | md_stall.
  - flush = redirect_valid & ex_valid & ~ex_hold. A redirect from a held EX instruction is deferred until EX advances.
- Output equations:
  - mem_wb_stall = 0; mem_wb_kill = mem_stall.
  - ex_mem_stall = mem_stall; ex_mem_kill = md_stall & ~mem_stall.
  - id_ex_stall = ex_hold; id_ex_kill = ~ex_hold & (flush | load_use).
  - if_id_stall = ex_hold | (load_use & ~flush); if_id_kill = flush.
  - flush_fire = flush.
- Flush has priority over load_use. A stall has priority over a kill on the same register; kills are meaningful only when that register is not stalled.
- stall_cycles increments by 1 every cycle if_id_stall=1 and wraps at 2^PERF_W.
- Reset mid-operation (M_REQ/M_WAIT or md_cnt>0) returns to idle immediately. A stale response arriving after reset is ignored.

Test Plan:
- Load x5 in EX, decode add using rs1=x5 -> one cycle of if_id_stall=1, id_ex_kill=1; next cycle both 0. Same scenario with ex_rd=0 or id_src1_is_reg=0 -> no stall.
- Muldiv enters EX, MULDIV_LAT=4 -> md_stall and id_ex_stall high 3 cycles, ex_mem_kill high 3 cycles, instruction leaves EX on the 4th cycle; md_cnt returns to 0.
- Load in MEM, dmem_req_ready low 2 cycles then high, response 3 cycles later -> dmem_req_valid high 3 cycles, ex_mem_stall high until the response cycle, mem_wb_kill mirrors it; stall_cycles advances by 6.
- redirect_valid while a mem stall is active -> flush_fire=0; first cycle mem_stall drops -> flush_fire=1, if_id_kill=1, id_ex_kill=1, if_id_stall=0 even with load_use=1.
- reset_n pulsed low while in M_WAIT, then dmem_resp_valid arrives -> FSM stays M_IDLE, all stall/kill outputs 0, stall_cycles=0.
